// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: turns EX/MEM load/store control into a
// req/ready memory transaction and stalls the pipeline while it is in flight.
// Optional macro MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES BUSY cycles.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemData_i,
  input  logic [2:0]  Funct3_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] RDdata_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rd_reg, rd_next;
  logic        err_reg, err_next;
  logic [2:0]  f3_reg, f3_next;
  logic [1:0]  off_reg, off_next;

  logic        op;
  logic        legal;
  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        timeout_hit;
  logic [7:0]  rd_lane [4];

  assign op  = MemRead_i | MemWrite_i;
  assign off = ALUResult_i[1:0];

  // Store-only sizes are rejected for the unsigned encodings.
  always_comb begin
    legal = 1'b0;
    case (Funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~off[0];
      3'b010:  legal = (off == 2'b00);
      3'b100:  legal = ~MemWrite_i;
      3'b101:  legal = ~MemWrite_i & ~off[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = MemData_i;
    case (Funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{MemData_i[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << off;
        st_wdata = {2{MemData_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = MemData_i;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = mem_rdata_i[8*gi +: 8];
  end

  assign ld_byte = rd_lane[off_reg];
  assign ld_half = off_reg[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    ld_fmt = mem_rdata_i;
    case (f3_reg)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = mem_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Counter is held at zero outside BUSY, so it is clear on every BUSY entry.
  assign cnt_next    = (state_reg == BUSY) ? cnt_reg + 1'b1 : '0;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    rd_next    = rd_reg;
    f3_next    = f3_reg;
    off_next   = off_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op && legal) begin
          req_next   = 1'b1;
          we_next    = MemWrite_i;
          addr_next  = {ALUResult_i[31:2], 2'b00};
          be_next    = MemWrite_i ? st_be : 4'b1111;
          wdata_next = MemWrite_i ? st_wdata : 32'h0;
          f3_next    = Funct3_i;
          off_next   = off;
          state_next = BUSY;
        end else if (op) begin
          err_next = 1'b1;
          rd_next  = 32'h0;
        end
      end
      BUSY: begin
        // Ready in the expiry cycle still completes normally.
        if (mem_ready_i) begin
          req_next   = 1'b0;
          if (!we_reg) rd_next = ld_fmt;
          state_next = DONE;
        end else if (timeout_hit) begin
          req_next   = 1'b0;
          rd_next    = 32'h0;
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'h0;
      be_reg    <= 4'h0;
      wdata_reg <= 32'h0;
      rd_reg    <= 32'h0;
      err_reg   <= 1'b0;
      f3_reg    <= 3'h0;
      off_reg   <= 2'h0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      rd_reg    <= rd_next;
      err_reg   <= err_next;
      f3_reg    <= f3_next;
      off_reg   <= off_next;
    end
  end

  // Gated by reset so the pipeline is released the instant reset asserts.
  assign stall_o = rst_i & (((state_reg == IDLE) & op & legal) | (state_reg == BUSY));

  assign mem_req_o   = req_reg;
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_be_o    = be_reg;
  assign mem_wdata_o = wdata_reg;
  assign RDdata_o    = rd_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: table-driven legal accesses,
// illegal accesses, mid-transaction reset and the BUSY timeout (or its absence).
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] ALUResult_i = 32'h0;
  logic [31:0] MemData_i = 32'h0;
  logic [2:0]  Funct3_i = 3'h0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] RDdata_o;
  logic        stall_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUResult_i (ALUResult_i),
    .MemData_i   (MemData_i),
    .Funct3_i    (Funct3_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .RDdata_o    (RDdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drop_op();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  // One legal access: accept, optional wait cycles, ready, DONE, back to IDLE.
  task automatic do_access(input vec_t v);
    MemRead_i   = v.rd;
    MemWrite_i  = v.wr;
    Funct3_i    = v.f3;
    ALUResult_i = v.addr;
    MemData_i   = v.wdata;
    #1;
    check({v.name, " stall_accept"}, 32'(stall_o), 32'd1);
    tick();
    drop_op();
    check({v.name, " req"}, 32'(mem_req_o), 32'd1);
    check({v.name, " we"}, 32'(mem_we_o), 32'(v.wr));
    check({v.name, " addr"}, mem_addr_o, v.exp_addr);
    check({v.name, " be"}, 32'(mem_be_o), 32'(v.exp_be));
    if (v.wr) check({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
    for (int i = 0; i < v.waits; i++) begin
      check({v.name, " stall_wait"}, 32'(stall_o), 32'd1);
      check({v.name, " req_hold"}, 32'(mem_req_o), 32'd1);
      tick();
    end
    check({v.name, " stall_ready"}, 32'(stall_o), 32'd1);
    mem_ready_i = 1'b1;
    mem_rdata_i = v.rdata;
    tick();
    mem_ready_i = 1'b0;
    check({v.name, " stall_done"}, 32'(stall_o), 32'd0);
    check({v.name, " req_done"}, 32'(mem_req_o), 32'd0);
    check({v.name, " err_done"}, 32'(err_o), 32'd0);
    check({v.name, " rddata"}, RDdata_o, v.exp_rd);
    $display("TXN %s addr=%h be=%b we=%b rd=%h", v.name, mem_addr_o, mem_be_o, mem_we_o, RDdata_o);
    tick();
  endtask

  initial begin
    vecs[0] = '{"LB_103",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1,
                32'h0000_0100, 4'b1111, 32'h0, 32'hFFFF_FF80};
    vecs[1] = '{"LHU_102",  1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0,
                32'h0000_0100, 4'b1111, 32'h0, 32'h0000_8001};
    vecs[2] = '{"SB_101",   1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0,
                32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 32'h0000_8001};
    vecs[3] = '{"SH_106",   1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h1234_CDEF, 32'h0, 1,
                32'h0000_0104, 4'b1100, 32'hCDEF_CDEF, 32'h0000_8001};
    vecs[4] = '{"RDWR_008", 1'b1, 1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 0,
                32'h0000_0008, 4'b1111, 32'hDEAD_BEEF, 32'h0000_8001};
    vecs[5] = '{"LH_002",   1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 2,
                32'h0000_0000, 4'b1111, 32'h0, 32'hFFFF_8001};
    vecs[6] = '{"LBU_001",  1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F000, 0,
                32'h0000_0000, 4'b1111, 32'h0, 32'h0000_00F0};
    vecs[7] = '{"LW_200",   1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0,
                32'h0000_0200, 4'b1111, 32'h0, 32'hCAFE_F00D};
    vecs[8] = '{"LB_000",   1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 0,
                32'h0000_0000, 4'b1111, 32'h0, 32'h0000_007F};

    // Reset state
    repeat (3) tick();
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_be", 32'(mem_be_o), 32'd0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_rd", RDdata_o, 32'h0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Illegal accesses: no request, no stall, single err pulse, RDdata cleared
    MemRead_i = 1'b1; Funct3_i = 3'b010; ALUResult_i = 32'h0000_0102;
    #1;
    check("lw_mis stall", 32'(stall_o), 32'd0);
    tick();
    drop_op();
    check("lw_mis req", 32'(mem_req_o), 32'd0);
    check("lw_mis err", 32'(err_o), 32'd1);
    check("lw_mis rd", RDdata_o, 32'h0);
    $display("TXN LW_102 illegal err=%b rd=%h", err_o, RDdata_o);
    tick();
    check("lw_mis err_pulse", 32'(err_o), 32'd0);

    MemWrite_i = 1'b1; Funct3_i = 3'b100; ALUResult_i = 32'h0000_0010;
    #1;
    check("sbu stall", 32'(stall_o), 32'd0);
    tick();
    drop_op();
    check("sbu err", 32'(err_o), 32'd1);
    check("sbu req", 32'(mem_req_o), 32'd0);
    $display("TXN SBU_010 illegal err=%b", err_o);
    tick();

    MemRead_i = 1'b1; Funct3_i = 3'b011; ALUResult_i = 32'h0000_0020;
    #1;
    check("f3_011 stall", 32'(stall_o), 32'd0);
    tick();
    drop_op();
    check("f3_011 err", 32'(err_o), 32'd1);
    $display("TXN F3_011 illegal err=%b", err_o);
    tick();

    // Reset while BUSY
    MemRead_i = 1'b1; Funct3_i = 3'b010; ALUResult_i = 32'h0000_0010;
    tick();
    check("rstbusy req_before", 32'(mem_req_o), 32'd1);
    check("rstbusy stall_before", 32'(stall_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("rstbusy req_async", 32'(mem_req_o), 32'd0);
    check("rstbusy stall_async", 32'(stall_o), 32'd0);
    drop_op();
    tick();
    rst_i = 1'b1;
    tick();
    check("rstbusy idle_stall", 32'(stall_o), 32'd0);
    check("rstbusy idle_req", 32'(mem_req_o), 32'd0);
    $display("TXN RESET_BUSY req=%b stall=%b", mem_req_o, stall_o);
    do_access(vecs[7]);

    // Long wait: timeout build aborts after 4 BUSY cycles, default build keeps waiting
    MemRead_i = 1'b1; Funct3_i = 3'b010; ALUResult_i = 32'h0000_0040;
    tick();
    drop_op();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("tmo req_hold", 32'(mem_req_o), 32'd1);
      check("tmo stall_hold", 32'(stall_o), 32'd1);
      tick();
    end
    check("tmo req_drop", 32'(mem_req_o), 32'd0);
    check("tmo err", 32'(err_o), 32'd1);
    check("tmo rd", RDdata_o, 32'h0);
    check("tmo stall_done", 32'(stall_o), 32'd0);
    $display("TXN TIMEOUT_040 err=%b rd=%h", err_o, RDdata_o);
    tick();
    check("tmo err_pulse", 32'(err_o), 32'd0);
    check("tmo idle_stall", 32'(stall_o), 32'd0);
`else
    repeat (20) tick();
    check("notmo req_hold", 32'(mem_req_o), 32'd1);
    check("notmo stall_hold", 32'(stall_o), 32'd1);
    check("notmo err", 32'(err_o), 32'd0);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1357_9BDF;
    tick();
    mem_ready_i = 1'b0;
    check("notmo rd", RDdata_o, 32'h1357_9BDF);
    check("notmo stall_done", 32'(stall_o), 32'd0);
    $display("TXN LONGWAIT_040 rd=%h", RDdata_o);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
